// File: rtl/ppu_pkg.sv
// Shared posit unit types: posit word, FIR operation result, special-result descriptor.
// Also holds the NaR helpers used by the normalization tail.
package ppu_pkg;

  localparam int PPU_N              = 16;
  localparam int PPU_ES             = 1;
  localparam int PPU_TE_BITS        = 7;
  localparam int PPU_FIR_TOTAL_SIZE = 43;
  localparam int PPU_FRAC_FULL_SIZE = 28;
  localparam int PPU_FIR_FRAC_W     = PPU_FIR_TOTAL_SIZE - 1 - PPU_TE_BITS;

  typedef logic [PPU_N-1:0] posit_t;

  // Value is (-1)^sign * 2^total_exponent * 1.frac
  typedef struct packed {
    logic                        sign;
    logic [PPU_TE_BITS-1:0]      total_exponent;
    logic [PPU_FIR_FRAC_W-1:0]   frac;
  } fir_t;

  typedef struct packed {
    fir_t fir;
    logic frac_truncated;
  } ops_out_meta_t;

  typedef struct packed {
    logic   special_tag;
    posit_t posit;
  } posit_special_t;

  function automatic logic [63:0] nar_word(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic is_nar(input posit_t p);
    return p == posit_t'(nar_word(PPU_N));
  endfunction

endpackage

// File: rtl/fir_to_posit.sv
// Combinational FIR-to-posit encoder with round-to-nearest-even on the bit pattern.
// Out-of-range magnitudes saturate to maxpos/minpos; never produces zero or NaR.
module fir_to_posit #(
  parameter int N              = 16,
  parameter int ES             = 1,
  parameter int FIR_TOTAL_SIZE = 43,
  parameter int TE_BITS        = 7,
  parameter int FRAC_FULL_SIZE = 28
) (
  input  logic [FIR_TOTAL_SIZE-1:0] fir_i,
  input  logic                      frac_truncated_i,
  output logic [N-1:0]              posit_o
);

  localparam int FW = FIR_TOTAL_SIZE - 1 - TE_BITS;
  localparam int LW = 2 + ES + FRAC_FULL_SIZE + N;
  localparam logic signed [TE_BITS-1:0] K_MAX  = TE_BITS'(N - 2);
  localparam logic        [TE_BITS-1:0] SH_MAX = TE_BITS'(N - 1);

  logic                      sign;
  logic signed [TE_BITS-1:0] te;
  logic signed [TE_BITS-1:0] k;
  logic [ES-1:0]             e;
  logic [FRAC_FULL_SIZE-1:0] frac_kept;
  logic                      frac_sticky;
  logic [TE_BITS-1:0]        sh;
  logic [LW-1:0]             body;
  logic [LW-1:0]             shifted;
  logic [N-2:0]              pre;
  logic [N-2:0]              mag;
  logic                      guard;
  logic                      sticky;
  logic                      round_up;

  always_comb begin
    sign        = fir_i[FIR_TOTAL_SIZE-1];
    te          = fir_i[FIR_TOTAL_SIZE-2 -: TE_BITS];
    frac_kept   = fir_i[FW-1 -: FRAC_FULL_SIZE];
    frac_sticky = (|fir_i[FW-FRAC_FULL_SIZE-1:0]) | frac_truncated_i;
    k           = te >>> ES;
    e           = te[ES-1:0];
    // Seed "10" (k>=0) or "01" (k<0); the arithmetic shift replicates the lead bit into the regime run.
    sh          = k[TE_BITS-1] ? ~k : k;
    if (sh > SH_MAX) sh = SH_MAX;
    body        = {(k[TE_BITS-1] ? 2'b01 : 2'b10), e, frac_kept, {N{1'b0}}};
    shifted     = $signed(body) >>> sh;
    pre         = shifted[LW-1 -: N-1];
    guard       = shifted[LW-N];
    sticky      = (|shifted[LW-N-1:0]) | frac_sticky;
    round_up    = guard & (pre[0] | sticky);
    mag         = pre + (N-1)'(round_up);
    if (k > K_MAX)       mag = '1;
    else if (k < -K_MAX) mag = (N-1)'(1);
    posit_o     = sign ? (~{1'b0, mag} + N'(1)) : {1'b0, mag};
  end

endmodule

// File: rtl/norm_pipe_stage.sv
// One elastic register slice: 1-cycle latency, accepts whenever empty or draining.
// Ready is combinational from downstream ready; payload only written by a valid load.
module norm_pipe_stage #(
  parameter int W = 21
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    in_ready_o = !valid_q || out_ready_i;
    valid_d    = in_ready_o ? in_valid_i : valid_q;
    data_d     = (in_ready_o && in_valid_i) ? in_data_i : data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/normalization_pipe.sv
// Posit normalization tail: FIR encode or special bypass, then PIPE_DEPTH elastic stages.
// Latency PIPE_DEPTH, 1/cycle; in_ready_o is the combinational ready chain; counts NaR outputs.
module normalization_pipe
  import ppu_pkg::*;
#(
  parameter int N              = PPU_N,
  parameter int ES             = PPU_ES,
  parameter int FIR_TOTAL_SIZE = PPU_FIR_TOTAL_SIZE,
  parameter int TE_BITS        = PPU_TE_BITS,
  parameter int FRAC_FULL_SIZE = PPU_FRAC_FULL_SIZE,
  parameter int PIPE_DEPTH     = 2,
  parameter int TAG_W          = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  ops_out_meta_t    ops_result_i,
  input  posit_special_t   p_special_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output posit_t           posit_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             special_o,
  input  logic             clear_i,
  output logic [CNT_W-1:0] nar_count_o
);

  localparam int PW = N + TAG_W + 1;

  posit_t            conv_posit;
  posit_t            in_posit;
  logic [PIPE_DEPTH:0] vld_chain;
  logic [PIPE_DEPTH:0] rdy_chain;
  logic [PW-1:0]     dat_chain [0:PIPE_DEPTH];
  logic [CNT_W-1:0]  nar_count_q, nar_count_d;

  fir_to_posit #(
    .N              (N),
    .ES             (ES),
    .FIR_TOTAL_SIZE (FIR_TOTAL_SIZE),
    .TE_BITS        (TE_BITS),
    .FRAC_FULL_SIZE (FRAC_FULL_SIZE)
  ) u_fir_to_posit (
    .fir_i            (ops_result_i.fir),
    .frac_truncated_i (ops_result_i.frac_truncated),
    .posit_o          (conv_posit)
  );

  assign in_posit     = p_special_i.special_tag ? p_special_i.posit : conv_posit;
  assign vld_chain[0] = in_valid_i;
  assign dat_chain[0] = {in_posit, tag_i, p_special_i.special_tag};
  assign rdy_chain[PIPE_DEPTH] = out_ready_i;
  assign in_ready_o   = rdy_chain[0];

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    norm_pipe_stage #(.W(PW)) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (vld_chain[k]),
      .in_ready_o  (rdy_chain[k]),
      .in_data_i   (dat_chain[k]),
      .out_valid_o (vld_chain[k+1]),
      .out_ready_i (rdy_chain[k+1]),
      .out_data_o  (dat_chain[k+1])
    );
  end

  assign out_valid_o = vld_chain[PIPE_DEPTH];
  assign {posit_o, tag_o, special_o} = dat_chain[PIPE_DEPTH];

  // Clear wins over a same-cycle count; the count sticks at all-ones.
  always_comb begin
    nar_count_d = nar_count_q;
    if (clear_i)
      nar_count_d = '0;
    else if (out_valid_o && out_ready_i && is_nar(posit_o) && (nar_count_q != '1))
      nar_count_d = nar_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) nar_count_q <= '0;
    else       nar_count_q <= nar_count_d;
  end

  assign nar_count_o = nar_count_q;

endmodule

// File: tb/tb_normalization_pipe.sv
// Directed and random checks of normalization_pipe against hand values and a bit-serial posit model.
module tb_normalization_pipe;
  import ppu_pkg::*;

  typedef struct {
    logic [15:0] posit;
    logic [3:0]  tag;
    logic        sp;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready_o;
  ops_out_meta_t  ops;
  posit_special_t psp;
  logic [3:0]     tag_in;
  logic           out_valid_o, out_ready;
  posit_t         posit_o;
  logic [3:0]     tag_o;
  logic           special_o;
  logic           clear;
  logic [15:0]    nar_o;

  logic           b_in_valid, b_in_ready, b_out_valid, b_special;
  posit_special_t b_psp;
  posit_t         b_posit;
  logic [3:0]     b_tag;
  logic [1:0]     b_nar;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_in     = 0;
  int   base     = 0;
  exp_t sbq[$];
  exp_t pend;
  exp_t held;
  logic was_stall = 1'b0;
  int   seen_valid;

  always #5 clk = ~clk;

  normalization_pipe u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .ops_result_i(ops), .p_special_i(psp), .tag_i(tag_in),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .posit_o(posit_o),
    .tag_o(tag_o), .special_o(special_o), .clear_i(clear), .nar_count_o(nar_o)
  );

  normalization_pipe #(.CNT_W(2)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .ops_result_i(ops), .p_special_i(b_psp), .tag_i(tag_in),
    .out_valid_o(b_out_valid), .out_ready_i(1'b1), .posit_o(b_posit),
    .tag_o(b_tag), .special_o(b_special), .clear_i(1'b0), .nar_count_o(b_nar)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bit-serial posit encoding: regime, exponent and fraction bits appended one at a time.
  function automatic logic [15:0] ref_posit(input ops_out_meta_t m);
    int       te, k, e, d;
    bit       bits[$];
    logic [14:0] mag;
    logic [15:0] r;
    bit       guard, sticky;
    d  = 1 << PPU_ES;
    te = int'($signed(m.fir.total_exponent));
    k  = (te >= 0) ? te / d : -((d - 1 - te) / d);
    e  = te - k * d;
    if (k > 14) mag = 15'h7FFF;
    else if (k < -14) mag = 15'h0001;
    else begin
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = PPU_ES - 1; i >= 0; i--) bits.push_back(((e >> i) & 1) != 0);
      for (int i = PPU_FIR_FRAC_W - 1; i >= 0; i--) bits.push_back(m.fir.frac[i]);
      mag = '0;
      for (int i = 0; i < 15; i++) mag = {mag[13:0], bits[i]};
      guard  = bits[15];
      sticky = m.frac_truncated;
      for (int i = 16; i < bits.size(); i++) sticky |= bits[i];
      if (guard && (mag[0] || sticky)) mag = mag + 15'd1;
    end
    r = {1'b0, mag};
    if (m.fir.sign) r = -r;
    return r;
  endfunction

  task automatic drive_special(input logic [15:0] p, input logic [3:0] t);
    in_valid        = 1'b1;
    ops             = '0;
    psp.special_tag = 1'b1;
    psp.posit       = p;
    tag_in          = t;
    pend            = '{p, t, 1'b1};
  endtask

  task automatic drive_fir(input logic s, input logic [6:0] te, input logic [34:0] fr,
                           input logic tr, input logic [3:0] t, input logic [15:0] exp);
    in_valid                = 1'b1;
    ops.fir.sign            = s;
    ops.fir.total_exponent  = te;
    ops.fir.frac            = fr;
    ops.frac_truncated      = tr;
    psp                     = '0;
    tag_in                  = t;
    pend                    = '{exp, t, 1'b0};
  endtask

  // One cycle: sample just after the driving negedge, score transfers, advance to next negedge.
  task automatic step();
    exp_t e;
    #1;
    if (was_stall) begin
      check("hold_posit", posit_o, held.posit);
      check("hold_tag", tag_o, held.tag);
      check("hold_special", special_o, held.sp);
    end
    if (in_valid && in_ready_o) begin
      sbq.push_back(pend);
      n_in++;
    end
    if (out_valid_o && out_ready) begin
      if (sbq.size() == 0) check("out_unexpected", out_valid_o, 0);
      else begin
        e = sbq.pop_front();
        check("out_posit", posit_o, e.posit);
        check("out_tag", tag_o, e.tag);
        check("out_special", special_o, e.sp);
      end
    end
    was_stall = out_valid_o && !out_ready;
    held      = '{posit_o, tag_o, special_o};
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ops ='0; psp = '0; tag_in = '0; in_valid = 0; out_ready = 0; clear = 0;
    b_in_valid = 0; b_psp = '{1'b1, 16'h8000};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_posit", posit_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_special", special_o, 0);
    check("rst_nar", nar_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    @(negedge clk);
    seen_valid = 0;
    repeat (4) begin seen_valid += int'(out_valid_o); step(); end
    check("idle_valid", seen_valid, 0);

    // Special bypass with exact 2-cycle latency
    out_ready = 1'b1;
    drive_special(16'h4000, 4'hA);
    step();
    in_valid = 1'b0;
    check("lat_not_early", out_valid_o, 0);
    step();
    check("byp_valid", out_valid_o, 1);
    check("byp_posit", posit_o, 16'h4000);
    check("byp_tag", tag_o, 4'hA);
    check("byp_special", special_o, 1);
    step();

    // Hand-encoded conversions (posit16, es=1)
    drive_fir(0, 7'h00, 35'h0,           0, 4'h1, 16'h4000); step();
    drive_fir(0, 7'h01, 35'h0,           0, 4'h2, 16'h5000); step();
    drive_fir(0, 7'h7F, 35'h0,           0, 4'h3, 16'h3000); step();
    drive_fir(0, 7'h00, 35'h4_0000_0000, 0, 4'h4, 16'h4800); step();
    drive_fir(1, 7'h00, 35'h0,           0, 4'h5, 16'hC000); step();
    drive_fir(0, 7'h28, 35'h0,           0, 4'h6, 16'h7FFF); step();
    drive_fir(0, 7'h58, 35'h0,           0, 4'h7, 16'h0001); step();
    drive_fir(1, 7'h28, 35'h0,           0, 4'h8, 16'h8001); step();
    drive_fir(0, 7'h00, 35'h0_0040_0000, 0, 4'h9, 16'h4000); step();
    drive_fir(0, 7'h00, 35'h0_0040_0000, 1, 4'hA, 16'h4001); step();
    drive_fir(0, 7'h00, 35'h0_00C0_0000, 0, 4'hB, 16'h4002); step();
    drive_fir(0, 7'h1B, 35'h0,           0, 4'hC, 16'h7FFE); step();
    drive_fir(0, 7'h64, 35'h0,           0, 4'hD, 16'h0001); step();
    in_valid = 1'b0;
    repeat (4) step();
    check("dir_drained", sbq.size(), 0);

    // Backpressure: pipe fills to 2, then drains in order
    out_ready = 1'b0;
    base = n_in;
    repeat (4) begin
      drive_special(16'h2000 + 16'(n_in - base), 4'(n_in - base));
      step();
    end
    check("bp_accepted", n_in - base, 2);
    drive_special(16'h2000 + 16'(n_in - base), 4'(n_in - base));
    #1;
    check("bp_in_ready_low", in_ready_o, 0);
    check("bp_head_tag", tag_o, 0);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_rise", in_ready_o, 1);
    for (int c = 0; c < 40 && ((n_in - base) < 5 || sbq.size() > 0); c++) begin
      if ((n_in - base) < 5) drive_special(16'h2000 + 16'(n_in - base), 4'(n_in - base));
      else in_valid = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("bp_count", n_in - base, 5);
    check("bp_drained", sbq.size(), 0);

    // NaR counting and clear priority
    clear = 1'b1; step(); clear = 1'b0;
    check("nar_cleared", nar_o, 0);
    drive_special(16'h8000, 4'h1); step();
    drive_special(16'h0000, 4'h2); step();
    drive_special(16'h8000, 4'h3); step();
    drive_special(16'h8000, 4'h4); step();
    in_valid = 1'b0;
    repeat (5) step();
    check("nar_three", nar_o, 3);
    out_ready = 1'b0;
    drive_special(16'h8000, 4'h5); step();
    in_valid = 1'b0;
    step();
    check("nar_stalled_valid", out_valid_o, 1);
    out_ready = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("nar_clear_prio", nar_o, 0);
    step();
    check("nar_clear_hold", nar_o, 0);

    // Saturation with a 2-bit counter
    repeat (5) begin b_in_valid = 1'b1; @(negedge clk); end
    b_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("nar_saturate", b_nar, 3);

    // Mid-flight reset discards both stages immediately
    out_ready = 1'b0;
    drive_special(16'h1234, 4'h5); step();
    drive_special(16'h5678, 4'h6); step();
    in_valid = 1'b0;
    check("mr_pre_valid", out_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_valid_drop", out_valid_o, 0);
    check("mr_posit_zero", posit_o, 0);
    sbq.delete();
    was_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen_valid = 0;
    repeat (5) begin seen_valid += int'(out_valid_o); step(); end
    check("mr_no_stale", seen_valid, 0);

    // Random valid/ready against the model
    base = n_in;
    for (int c = 0; c < 40000 && (n_in - base) < 10000; c++) begin
      if ($urandom_range(0, 7) == 0)
        drive_special(($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom), 4'($urandom));
      else begin
        ops_out_meta_t m;
        m.fir.sign           = 1'($urandom);
        m.fir.total_exponent = 7'($urandom);
        m.fir.frac           = {3'($urandom), 32'($urandom)};
        m.frac_truncated     = 1'($urandom);
        drive_fir(m.fir.sign, m.fir.total_exponent, m.fir.frac, m.frac_truncated,
                  4'($urandom), ref_posit(m));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    check("rand_ops", n_in - base, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sbq.size() > 0; c++) step();
    check("rand_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
